// File: rtl/ssc_miter_divergence_monitor.sv
// Divergence monitor between two miter instances: compares masked channels over a DEPTH-cycle
// window after a start pulse. Optional per-channel mismatch counters via SSC_MITER_CNT_EN.
module ssc_miter_divergence_monitor #(
   parameter int unsigned NUM_CH      = 8,
   parameter int unsigned CH_W        = 32,
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned STOP_ON_DIV = 0,
   parameter int unsigned CNT_W       = 8,
   localparam int unsigned OFS_W = $clog2(DEPTH + 1),
   localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     abort,
   input  logic [NUM_CH-1:0]        ch_mask,
   input  logic [NUM_CH*CH_W-1:0]   inst_a,
   input  logic [NUM_CH*CH_W-1:0]   inst_b,
   output logic                     busy,
   output logic                     res_valid,
   input  logic                     res_ack,
   output logic                     diverged,
   output logic [OFS_W-1:0]         first_ofs,
   output logic [IDX_W-1:0]         first_ch,
   output logic [NUM_CH-1:0]        div_vec,
`ifdef SSC_MITER_CNT_EN
   output logic [NUM_CH*CNT_W-1:0]  mis_cnt,
`endif
   output logic                     start_err
);

   typedef enum logic [1:0] {StIdle, StObserve, StDone} state_e;

   state_e              state_q, state_d;
   logic [NUM_CH-1:0]   mask_q;
   logic [NUM_CH-1:0]   mis;
   logic [NUM_CH-1:0]   div_vec_q;
   logic [OFS_W-1:0]    ofs_q;
   logic [OFS_W-1:0]    first_ofs_q;
   logic [IDX_W-1:0]    first_ch_q;
   logic [IDX_W-1:0]    low_idx;
   logic                diverged_q;
   logic                accept;
   logic                last_cmp;

   // Descending scan leaves the lowest mismatching channel in low_idx.
   always_comb begin
      mis     = '0;
      low_idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         mis[i] = mask_q[i] && (inst_a[i*CH_W +: CH_W] != inst_b[i*CH_W +: CH_W]);
         if (mis[i]) begin
            low_idx = IDX_W'(i);
         end
      end
   end

   assign accept   = (state_q == StIdle) && start && !abort;
   assign last_cmp = (ofs_q == OFS_W'(DEPTH)) || ((STOP_ON_DIV != 0) && (mis != '0));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle:    if (start) state_d = StObserve;
            StObserve: if (last_cmp) state_d = StDone;
            StDone:    if (res_ack) state_d = StIdle;
            default:   state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      busy      = (state_q == StObserve);
      res_valid = (state_q == StDone);
      start_err = start && (state_q != StIdle);
      diverged  = diverged_q;
      first_ofs = first_ofs_q;
      first_ch  = first_ch_q;
      div_vec   = div_vec_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mask_q      <= '0;
         ofs_q       <= '0;
         diverged_q  <= 1'b0;
         first_ofs_q <= '0;
         first_ch_q  <= '0;
         div_vec_q   <= '0;
      end else if (abort) begin
         ofs_q       <= '0;
         diverged_q  <= 1'b0;
         first_ofs_q <= '0;
         first_ch_q  <= '0;
         div_vec_q   <= '0;
      end else if (accept) begin
         mask_q      <= ch_mask;
         ofs_q       <= OFS_W'(1);
         diverged_q  <= 1'b0;
         first_ofs_q <= '0;
         first_ch_q  <= '0;
         div_vec_q   <= '0;
      end else if (state_q == StObserve) begin
         div_vec_q <= div_vec_q | mis;
         if ((mis != '0) && !diverged_q) begin
            diverged_q  <= 1'b1;
            first_ofs_q <= ofs_q;
            first_ch_q  <= low_idx;
         end
         // Offset freezes on the final compare so it can never pass DEPTH.
         if (!last_cmp) begin
            ofs_q <= ofs_q + 1'b1;
         end
      end
   end

`ifdef SSC_MITER_CNT_EN
   logic [NUM_CH-1:0][CNT_W-1:0] cnt_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (abort || accept) begin
         cnt_q <= '0;
      end else if (state_q == StObserve) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (mis[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign mis_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_ssc_miter_divergence_monitor.sv
// Scoreboard bench: directed windows push hand-computed results; per-instance monitors pop and
// compare when res_valid rises. Instance 1 runs with STOP_ON_DIV=1 on the same stimulus.
module tb_ssc_miter_divergence_monitor;

   localparam int unsigned DEPTH = 16;

   typedef struct {
      logic       dv;
      logic [4:0] fo;
      logic [2:0] fc;
      logic [7:0] vec;
      int         lat;   // 0: no result expected from this instance
   } exp_t;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic         res_ack = 1'b0;
   logic [7:0]   ch_mask = '0;
   logic [255:0] inst_a = '0;
   logic [255:0] inst_b = '0;

   logic       busy0, rv0, dv0, serr0;
   logic [4:0] fo0;
   logic [2:0] fc0;
   logic [7:0] dvec0;
   logic       busy1, rv1, dv1, serr1;
   logic [4:0] fo1;
   logic [2:0] fc1;
   logic [7:0] dvec1;

   exp_t q0[$];
   exp_t q1[$];
   int   checks = 0;
   int   passed = 0;
   int   cyc = 0;
   int   start_cyc = 0;
   logic rv0_d = 1'b0;
   logic rv1_d = 1'b0;

`ifdef SSC_MITER_CNT_EN
   logic [63:0]  cnt0, cnt1, cntc;
   logic         start_c = 1'b0;
   logic [7:0]   mask_c = 8'h01;
   logic [255:0] a_c = '0;
   logic [255:0] b_c = 256'h1;
   logic         busyc, rvc, dvc, serrc;
   logic [8:0]   foc;
   logic [2:0]   fcc;
   logic [7:0]   dvecc;
`endif

   ssc_miter_divergence_monitor #(.NUM_CH(8), .CH_W(32), .DEPTH(DEPTH), .STOP_ON_DIV(0)) dut (
      .clock(clock), .reset(reset), .start(start), .abort(abort), .ch_mask(ch_mask),
      .inst_a(inst_a), .inst_b(inst_b), .busy(busy0), .res_valid(rv0), .res_ack(res_ack),
      .diverged(dv0), .first_ofs(fo0), .first_ch(fc0), .div_vec(dvec0),
`ifdef SSC_MITER_CNT_EN
      .mis_cnt(cnt0),
`endif
      .start_err(serr0)
   );

   ssc_miter_divergence_monitor #(.NUM_CH(8), .CH_W(32), .DEPTH(DEPTH), .STOP_ON_DIV(1)) dut_s (
      .clock(clock), .reset(reset), .start(start), .abort(abort), .ch_mask(ch_mask),
      .inst_a(inst_a), .inst_b(inst_b), .busy(busy1), .res_valid(rv1), .res_ack(res_ack),
      .diverged(dv1), .first_ofs(fo1), .first_ch(fc1), .div_vec(dvec1),
`ifdef SSC_MITER_CNT_EN
      .mis_cnt(cnt1),
`endif
      .start_err(serr1)
   );

`ifdef SSC_MITER_CNT_EN
   ssc_miter_divergence_monitor #(.NUM_CH(8), .CH_W(32), .DEPTH(300), .STOP_ON_DIV(0)) dut_c (
      .clock(clock), .reset(reset), .start(start_c), .abort(1'b0), .ch_mask(mask_c),
      .inst_a(a_c), .inst_b(b_c), .busy(busyc), .res_valid(rvc), .res_ack(1'b0),
      .diverged(dvc), .first_ofs(foc), .first_ch(fcc), .div_vec(dvecc), .mis_cnt(cntc),
      .start_err(serrc)
   );
`endif

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic check_res(input string tag, input exp_t e, input logic dv, input logic [4:0] fo,
                            input logic [2:0] fc, input logic [7:0] vec);
      chk({tag, " diverged"}, dv, e.dv);
      chk({tag, " first_ofs"}, fo, e.fo);
      chk({tag, " first_ch"}, fc, e.fc);
      chk({tag, " div_vec"}, vec, e.vec);
      chk({tag, " latency"}, cyc - start_cyc, e.lat);
   endtask

   always @(negedge clock) begin
      if (rv0 && !rv0_d) begin
         if (q0.size() == 0) chk("dut unexpected res_valid", rv0, 1'b0);
         else check_res("dut", q0.pop_front(), dv0, fo0, fc0, dvec0);
      end
      if (rv1 && !rv1_d) begin
         if (q1.size() == 0) chk("dut_s unexpected res_valid", rv1, 1'b0);
         else check_res("dut_s", q1.pop_front(), dv1, fo1, fc1, dvec1);
      end
      rv0_d <= rv0;
      rv1_d <= rv1;
   end

   task automatic drive_data(input logic [7:0] mm);
      for (int i = 0; i < 8; i++) begin
         logic [31:0] a;
         a = $urandom();
         inst_a[i*32 +: 32] = a;
         inst_b[i*32 +: 32] = mm[i] ? ~a : a;
      end
   endtask

   // Mismatches v1 at offset o1 and v2 at o2; extra start at err_ofs; abort at abort_ofs.
   task automatic run_window(input logic [7:0] mask, input int o1, input logic [7:0] v1,
                             input int o2, input logic [7:0] v2, input int err_ofs,
                             input int abort_ofs, input bit ack_start, input exp_t e0,
                             input exp_t e1);
      int n;
      ch_mask = mask;
      start = 1'b1;
      drive_data(8'hFF);   // start cycle must not be compared
      start_cyc = cyc;
      if (e0.lat != 0) q0.push_back(e0);
      if (e1.lat != 0) q1.push_back(e1);
      @(posedge clock); #1;
      start = 1'b0;
      ch_mask = ~mask;     // mask is latched at start
      for (int k = 1; k <= DEPTH; k++) begin
         drive_data(((k == o1) ? v1 : 8'h00) | ((k == o2) ? v2 : 8'h00));
         start = (k == err_ofs);
         abort = (k == abort_ofs);
         if (k == err_ofs) begin
            @(negedge clock);
            chk("start_err pulse", serr0, 1'b1);
            chk("busy during start_err", busy0, 1'b1);
         end
         @(posedge clock); #1;
         start = 1'b0;
         if (k == abort_ofs) begin
            abort = 1'b0;
            chk("abort busy", busy0, 1'b0);
            chk("abort res_valid", rv0, 1'b0);
            chk("abort diverged", dv0, 1'b0);
            chk("abort div_vec", dvec0, 8'h00);
            chk("abort dut_s res_valid", rv1, 1'b0);
            chk("abort dut_s div_vec", dvec1, 8'h00);
            return;
         end
      end
      n = 0;
      while (!(rv0 && rv1) && n < 40) begin
         @(posedge clock); #1;
         n++;
      end
      chk("result within bound", rv0 && rv1, 1'b1);
      @(negedge clock);
      @(posedge clock); #1;
      chk("res_valid held", rv0, 1'b1);
      res_ack = 1'b1;
      start = ack_start;
      if (ack_start) begin
         @(negedge clock);
         chk("start_err with ack", serr0, 1'b1);
      end
      @(posedge clock); #1;
      res_ack = 1'b0;
      start = 1'b0;
      chk("idle after ack", {busy0, rv0}, 2'b00);
   endtask

   initial begin
      #3;
      chk("reset outputs dut", {busy0, rv0, dv0, fo0, fc0, dvec0, serr0}, 20'h0);
      chk("reset outputs dut_s", {busy1, rv1, dv1, fo1, fc1, dvec1, serr1}, 20'h0);
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;

      // T1: no divergence, full window
      run_window(8'hFF, 0, 8'h00, 0, 8'h00, 0, 0, 1'b0,
                 '{1'b0, 5'd0, 3'd0, 8'h00, 17}, '{1'b0, 5'd0, 3'd0, 8'h00, 17});
      // T2: ch5@3, ch2@7, stray start at offset 2
      run_window(8'hFF, 3, 8'h20, 7, 8'h04, 2, 0, 1'b0,
                 '{1'b1, 5'd3, 3'd5, 8'h24, 17}, '{1'b1, 5'd3, 3'd5, 8'h20, 4});
`ifdef SSC_MITER_CNT_EN
      chk("cnt ch5", cnt0[47:40], 8'd1);
      chk("cnt ch2", cnt0[23:16], 8'd1);
      chk("cnt ch0", cnt0[7:0], 8'd0);
`endif
      // T3: masked-out mismatch, plus start together with ack
      run_window(8'hDF, 3, 8'h20, 0, 8'h00, 0, 0, 1'b1,
                 '{1'b0, 5'd0, 3'd0, 8'h00, 17}, '{1'b0, 5'd0, 3'd0, 8'h00, 17});
      // T4: ch1+ch6 @4
      run_window(8'hFF, 4, 8'h42, 0, 8'h00, 0, 0, 1'b0,
                 '{1'b1, 5'd4, 3'd1, 8'h42, 17}, '{1'b1, 5'd4, 3'd1, 8'h42, 5});
      // Last offset only
      run_window(8'hFF, 16, 8'h80, 0, 8'h00, 0, 0, 1'b0,
                 '{1'b1, 5'd16, 3'd7, 8'h80, 17}, '{1'b1, 5'd16, 3'd7, 8'h80, 17});
      // First offset, partially masked
      run_window(8'hF7, 1, 8'h48, 9, 8'h08, 0, 0, 1'b0,
                 '{1'b1, 5'd1, 3'd6, 8'h40, 17}, '{1'b1, 5'd1, 3'd6, 8'h40, 2});
      // T5: stray start at 3, abort at 5
      run_window(8'hFF, 2, 8'h01, 0, 8'h00, 3, 5, 1'b0,
                 '{1'b0, 5'd0, 3'd0, 8'h00, 0}, '{1'b1, 5'd2, 3'd0, 8'h01, 3});

      // start+abort together in IDLE: not armed
      start = 1'b1;
      abort = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      abort = 1'b0;
      chk("start+abort busy", busy0, 1'b0);
      chk("start+abort dut_s busy", busy1, 1'b0);

      // T6: async reset in the middle of offset 9
      ch_mask = 8'hFF;
      start = 1'b1;
      drive_data(8'h00);
      start_cyc = cyc;
      q1.push_back('{1'b1, 5'd2, 3'd0, 8'h01, 3});
      @(posedge clock); #1;
      start = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         drive_data((k == 2) ? 8'h01 : 8'h00);
         @(posedge clock); #1;
      end
      chk("pre-reset diverged", dv0, 1'b1);
      chk("pre-reset busy", busy0, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      chk("async reset dut", {busy0, rv0, dv0, fo0, fc0, dvec0, serr0}, 20'h0);
      chk("async reset dut_s", {busy1, rv1, dv1, fo1, fc1, dvec1, serr1}, 20'h0);
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;

`ifdef SSC_MITER_CNT_EN
      begin
         int n;
         start_c = 1'b1;
         @(posedge clock); #1;
         start_c = 1'b0;
         n = 0;
         while (!rvc && n < 320) begin
            @(posedge clock); #1;
            n++;
         end
         chk("cnt window done", rvc, 1'b1);
         chk("cnt saturated ch0", cntc[7:0], 8'd255);
         chk("cnt ch1 zero", cntc[15:8], 8'd0);
         chk("cnt first_ofs", foc, 9'd1);
      end
`endif

      repeat (3) @(posedge clock);
      chk("dut results pending", q0.size(), 0);
      chk("dut_s results pending", q1.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
